// File: rtl/jk_seq_pkg.sv
// Shared types and the JK excitation function for the JK sequence driver.
package jk_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Returns {j,k}. A JK flop can reach a new value by toggling or by an explicit set/reset.
  function automatic logic [1:0] jk_excite(input logic cur, input logic tgt,
                                           input logic use_toggle);
    if (cur == tgt) begin
      return 2'b00;
    end else if (use_toggle) begin
      return 2'b11;
    end else begin
      return {tgt, ~tgt};
    end
  endfunction

endpackage

// File: rtl/jk_excite_unit.sv
// Combinational JK excitation: the J/K pair that moves a JK flop from cur to tgt.
module jk_excite_unit
  import jk_seq_pkg::*;
#(
  parameter int USE_TOGGLE = 1
) (
  input  logic cur,
  input  logic tgt,
  output logic j,
  output logic k
);

  assign {j, k} = jk_excite(cur, tgt, USE_TOGGLE != 0);

endmodule

// File: rtl/jk_seq_driver.sv
// Drives a JK flip-flop through a handshaked stream of target Q bits.
// Define JK_SEQ_CHECK_EN to build the Q-reached-target checker (err/err_cnt).
module jk_seq_driver
  import jk_seq_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int USE_TOGGLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             init_val,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             set,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] err_cnt
);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   last_idx;
  logic               init_q;
  logic               ex_j, ex_k;
  logic               accept;
  logic               start_acc;

  assign start_acc = (state == IDLE) && start;
  assign accept    = (state == RUN) && tgt_valid;
  assign last_idx  = len_q - LEN_W'(1);

  jk_excite_unit #(
    .USE_TOGGLE (USE_TOGGLE)
  ) u_excite (
    .cur (q_fb),
    .tgt (tgt_bit),
    .j   (ex_j),
    .k   (ex_k)
  );

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nxt = state;
    j         = 1'b0;
    k         = 1'b0;
    set       = 1'b0;
    tgt_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? FIN : INIT;
        end
      end
      INIT: begin
        if (init_q) begin
          set = 1'b1;
        end else begin
          k = 1'b1;
        end
        state_nxt = RUN;
      end
      RUN: begin
        tgt_ready = 1'b1;
        if (tgt_valid) begin
          j = ex_j;
          k = ex_k;
          if (cnt == last_idx) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      len_q  <= '0;
      init_q <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == FIN);
      if (start_acc) begin
        len_q  <= len;
        init_q <= init_val;
        cnt    <= '0;
      end else if (accept) begin
        cnt <= cnt + LEN_W'(1);
      end
    end
  end

`ifdef JK_SEQ_CHECK_EN
  logic exp_q;
  logic chk_pend;

  // Each accepted bit is checked against q_fb on the cycle after its edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q    <= 1'b0;
      chk_pend <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      chk_pend <= accept;
      if (accept) begin
        exp_q <= tgt_bit;
      end
      if (start_acc) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end else if (chk_pend && (state == RUN || state == DRAIN) && (q_fb != exp_q)) begin
        err <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + LEN_W'(1);
        end
      end
    end
  end
`else
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

endmodule
